dsp_voice_scheduler: RTL and testbench
======================================

DSP_VOICE_SCHEDULER -- requirements
Module: dsp_voice_scheduler

Interface
REQ-001 Parameter N_VOICES, default 8: voice count, legal range 1..16.
REQ-002 Parameter N_MAJOR_STEPS, default 32: major steps per sample period.
REQ-003 Parameter N_MINOR_STEPS, default 3: clock cycles per major step, legal range 1..8.
REQ-004 Parameter N_VSTATES, default 9: voice states S1..S(N_VSTATES); the last state is idle; must be <= N_MAJOR_STEPS.
REQ-005 Parameters S1_BASE, default 0, and S1_STRIDE, default 3: voice v enters S1 at major step (S1_BASE + v*S1_STRIDE) mod N_MAJOR_STEPS.
REQ-006 clock  input  1  sole clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 run  input  1  advance enable; when low, all counters and states hold.
REQ-009 restart  input  1  synchronous re-phase to step 0; takes priority over run.
REQ-010 minor_step  output  N_MINOR_STEPS  one-hot minor step.
REQ-011 major_step  output  clog2(N_MAJOR_STEPS)  binary major step index.
REQ-012 voice_state  output  N_VOICES*N_VSTATES  per-voice one-hot state; voice v occupies bits [v*N_VSTATES +: N_VSTATES].
REQ-013 voice_s1_pulse  output  N_VOICES  one-cycle pulse on S1 entry.
REQ-014 sample_strobe  output  1  one-cycle pulse at each sample-period wrap.

Function
REQ-015 Counter advance: on each edge with run=1 and restart=0, minor_step rotates left by one bit.
REQ-016 major_step increments when minor_step leaves its MSB, wrapping N_MAJOR_STEPS-1 -> 0; the period is N_MAJOR_STEPS*N_MINOR_STEPS cycles (96 at defaults).
REQ-017 State derivation: d = (major_step - start_v) mod N_MAJOR_STEPS; voice v is in S(d+1) if d < N_VSTATES-1, otherwise in the idle state.
REQ-018 Voice states are registered and update in the same edge as major_step, so voice_state is always consistent with major_step.
REQ-019 voice_s1_pulse[v] is high for exactly the one cycle following the edge on which major_step becomes start_v with minor_step=1.
REQ-020 sample_strobe is high for exactly the one cycle following the edge on which major_step wraps to 0.
REQ-021 restart=1: the next edge loads the reset values (REQ-024) regardless of run, and all pulses are low in the following cycle.
REQ-022 run low mid-step: all outputs hold; pulses deassert after one cycle and do not re-fire while held.
REQ-023 Voices with equal start_v (overlap when S1_STRIDE*v wraps) are legal and track identically.

Reset
REQ-024 While reset=0, asynchronously: minor_step=1; major_step=0; each voice is in its REQ-017 state for major_step=0; voice_s1_pulse=0; sample_strobe=0.
REQ-025 No S1 pulse is generated for states loaded by reset or restart.
REQ-026 Reset asserted mid-period takes effect immediately, with no completion of the current step.

Configuration
REQ-027 With DSP_SCHED_SAMPLE_COUNT_EN defined: a 16-bit output sample_count is present; it resets to 0, increments on every sample_strobe, wraps 65535 -> 0, and is cleared by restart.
REQ-028 Without DSP_SCHED_SAMPLE_COUNT_EN: the sample_count port and its logic are absent; all other behaviour is identical.

Verification
REQ-029 Release reset with run=1 at defaults -> sample_strobe high after edges 96 and 192 only; major_step=31 after edge 95.
REQ-030 At defaults, after reset -> voice 0 is in S1 and voices 1..7 are idle; after edge 9, voice_s1_pulse=8'b0000_0010 and voice 1 is in S1.
REQ-031 After 24 edges at defaults -> voice 0 is in S9 (idle), voice 2 is in S3, and voice 7 is idle.
REQ-032 Hold run=0 for 10 cycles at major_step=5 -> all outputs unchanged; resume -> sample_strobe slips by exactly 10 cycles.
REQ-033 Assert restart at major_step=20 with run=0 -> after the next edge major_step=0, minor_step=3'b001, and no pulses.
REQ-034 With DSP_SCHED_SAMPLE_COUNT_EN, N_MAJOR_STEPS=4 and N_MINOR_STEPS=1 -> sample_count=3 after 12 edges, and sample_count wraps to 0 after 262144 edges.

Source files
------------

// File: rtl/dsp_voice_scheduler.sv
// -----------------------------------------------------------------------------
// dsp_voice_scheduler
//
// Timing generator for a time-multiplexed voice engine. A one-hot minor-step
// ring walks through N_MINOR_STEPS clock cycles per major step. A binary
// major-step counter walks through N_MAJOR_STEPS major steps per sample
// period. Each voice is phase-shifted by its own start step and moves through
// the states S1..S(N_VSTATES). The last of these states is idle.
//
// Optional feature (macro DSP_SCHED_SAMPLE_COUNT_EN):
//   When this macro is defined, the block adds a 16-bit sample_count output.
//   It counts sample periods, wraps modulo 2^16, and is cleared by restart.
//
// Ports
//   clock           in   sole clock, rising edge
//   reset           in   asynchronous, active-low reset
//   run             in   advance enable; all state holds while low
//   restart         in   synchronous re-phase to step 0; overrides run
//   minor_step      out  one-hot minor step (bit 0 = first cycle of a step)
//   major_step      out  binary major step index
//   voice_state     out  per-voice one-hot state,
//                        voice v at [v*N_VSTATES +: N_VSTATES]
//   voice_s1_pulse  out  one-cycle pulse when a voice enters S1 by advancing
//   sample_strobe   out  one-cycle pulse when major_step wraps to 0
//   sample_count    out  (DSP_SCHED_SAMPLE_COUNT_EN only) sample period count
//
// Legal parameter ranges
//   N_VOICES        1..16
//   N_MINOR_STEPS   1..8
//   N_VSTATES       <= N_MAJOR_STEPS
//   S1_BASE         >= 0
//   S1_STRIDE       >= 0
// -----------------------------------------------------------------------------
module dsp_voice_scheduler #(
    parameter int N_VOICES      = 8,
    parameter int N_MAJOR_STEPS = 32,
    parameter int N_MINOR_STEPS = 3,
    parameter int N_VSTATES     = 9,
    parameter int S1_BASE       = 0,
    parameter int S1_STRIDE     = 3,
    localparam int MAJ_W        = (N_MAJOR_STEPS > 1) ? $clog2(N_MAJOR_STEPS) : 1,
    localparam int VS_W         = N_VOICES * N_VSTATES
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     restart,
    output logic [N_MINOR_STEPS-1:0] minor_step,
    output logic [MAJ_W-1:0]         major_step,
    output logic [VS_W-1:0]          voice_state,
    output logic [N_VOICES-1:0]      voice_s1_pulse,
    output logic                     sample_strobe
`ifdef DSP_SCHED_SAMPLE_COUNT_EN
    ,
    output logic [15:0]              sample_count
`endif
);

    localparam logic [MAJ_W-1:0] MAJ_LAST = MAJ_W'(N_MAJOR_STEPS - 1);

    // Major step at which voice v enters S1.
    function automatic int start_of(input int v);
        return (S1_BASE + v * S1_STRIDE) % N_MAJOR_STEPS;
    endfunction

    // Per-voice one-hot state vector for a given major step.
    // Each voice's distance past its start step is taken modulo the period.
    // Every distance beyond the last active state collapses to idle.
    function automatic logic [VS_W-1:0] states_at(input logic [MAJ_W-1:0] maj);
        logic [VS_W-1:0]      s;
        logic [N_VSTATES-1:0] oh;
        int                   m;
        int                   st;
        int                   d;
        s = '0;
        m = int'(maj);
        for (int v = 0; v < N_VOICES; v++) begin
            st = start_of(v);
            d  = (m >= st) ? (m - st) : (m + N_MAJOR_STEPS - st);
            if (d < N_VSTATES - 1)
                oh = N_VSTATES'(1) << d;
            else
                oh = N_VSTATES'(1) << (N_VSTATES - 1);
            s = s | (VS_W'(oh) << (v * N_VSTATES));
        end
        return s;
    endfunction

    // Mask of voices whose S1 begins at the given major step.
    // Several voices may share a start step.
    function automatic logic [N_VOICES-1:0] starts_at(input logic [MAJ_W-1:0] maj);
        logic [N_VOICES-1:0] p;
        p = '0;
        for (int v = 0; v < N_VOICES; v++) begin
            if (start_of(v) == int'(maj))
                p = p | (N_VOICES'(1) << v);
        end
        return p;
    endfunction

    localparam logic [VS_W-1:0] VS_RST = states_at(MAJ_W'(0));

    logic                     advance;
    logic                     step_done;
    logic [N_MINOR_STEPS-1:0] minor_nxt;
    logic [MAJ_W-1:0]         major_nxt;
    logic [N_VOICES-1:0]      pulse_nxt;
    logic                     strobe_nxt;

    // Next-state decode: counters, pulses and strobe computed from current outputs
    always_comb begin
        advance    = run && !restart;
        step_done  = 1'b0;
        minor_nxt  = minor_step;
        major_nxt  = major_step;
        if (advance) begin
            // Rotate left.
            // With N_MINOR_STEPS == 1 the single bit maps onto itself.
            minor_nxt = (minor_step << 1) | (minor_step >> (N_MINOR_STEPS - 1));
            if (minor_step[N_MINOR_STEPS-1]) begin
                step_done = 1'b1;
                major_nxt = (major_step == MAJ_LAST) ? '0 : major_step + MAJ_W'(1);
            end
        end
        // Pulses fire only on a real step advance.
        // Reset, restart and hold therefore never produce one.
        pulse_nxt  = step_done ? starts_at(major_nxt) : '0;
        strobe_nxt = step_done && (major_step == MAJ_LAST);
    end

    // Output register stage: voice states update together with major_step
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            minor_step     <= N_MINOR_STEPS'(1);
            major_step     <= '0;
            voice_state    <= VS_RST;
            voice_s1_pulse <= '0;
            sample_strobe  <= 1'b0;
        end else if (restart) begin
            minor_step     <= N_MINOR_STEPS'(1);
            major_step     <= '0;
            voice_state    <= VS_RST;
            voice_s1_pulse <= '0;
            sample_strobe  <= 1'b0;
        end else begin
            minor_step     <= minor_nxt;
            major_step     <= major_nxt;
            voice_state    <= states_at(major_nxt);
            voice_s1_pulse <= pulse_nxt;
            sample_strobe  <= strobe_nxt;
        end
    end

`ifdef DSP_SCHED_SAMPLE_COUNT_EN
    // Sample counter stage: counts on the same edge that raises sample_strobe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            sample_count <= '0;
        else if (restart)
            sample_count <= '0;
        else if (strobe_nxt)
            sample_count <= sample_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_dsp_voice_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dsp_voice_scheduler
//
// Self-checking bench for dsp_voice_scheduler at its default parameters.
// A table of directed vectors drives run=1 from reset and checks outputs at
// chosen edge counts. Hand-written sequences then cover the multi-cycle
// cases: strobe timing, hold with run low, restart, and async reset
// mid-period.
// -----------------------------------------------------------------------------
module tb_dsp_voice_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        restart = 1'b0;
    logic [2:0]  minor_step;
    logic [4:0]  major_step;
    logic [71:0] voice_state;
    logic [7:0]  voice_s1_pulse;
    logic        sample_strobe;
`ifdef DSP_SCHED_SAMPLE_COUNT_EN
    logic [15:0] sample_count;
`endif

    dsp_voice_scheduler dut (
        .clock          (clock),
        .reset          (reset),
        .run            (run),
        .restart        (restart),
        .minor_step     (minor_step),
        .major_step     (major_step),
        .voice_state    (voice_state),
        .voice_s1_pulse (voice_s1_pulse),
        .sample_strobe  (sample_strobe)
`ifdef DSP_SCHED_SAMPLE_COUNT_EN
        ,
        .sample_count   (sample_count)
`endif
    );

    always #5 clock = ~clock;

    localparam logic [8:0] IDLE = 9'h100;

    typedef struct {
        int         edge_n;
        logic [4:0] major;
        logic [2:0] minor;
        logic [7:0] pulse;
        logic       strobe;
        logic [8:0] v0;
        logic [8:0] v1;
        logic [8:0] v2;
        logic [8:0] v7;
    } vec_t;

    vec_t vecs [12];
    int   tests  = 0;
    int   failed = 0;
    int   edges  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Hold reset across two edges.
    // Release it on a falling edge so that the next rising edge is edge 1.
    task automatic do_reset();
        reset   = 1'b0;
        restart = 1'b0;
        run     = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        // edge, major, minor, pulse, strobe, voice0, voice1, voice2, voice7
        vecs[0]  = '{0,   5'd0,  3'b001, 8'h00, 1'b0, 9'h001, IDLE,   IDLE,   IDLE};
        vecs[1]  = '{1,   5'd0,  3'b010, 8'h00, 1'b0, 9'h001, IDLE,   IDLE,   IDLE};
        vecs[2]  = '{3,   5'd1,  3'b001, 8'h00, 1'b0, 9'h002, IDLE,   IDLE,   IDLE};
        vecs[3]  = '{9,   5'd3,  3'b001, 8'h02, 1'b0, 9'h008, 9'h001, IDLE,   IDLE};
        vecs[4]  = '{10,  5'd3,  3'b010, 8'h00, 1'b0, 9'h008, 9'h001, IDLE,   IDLE};
        vecs[5]  = '{24,  5'd8,  3'b001, 8'h00, 1'b0, IDLE,   9'h020, 9'h004, IDLE};
        vecs[6]  = '{63,  5'd21, 3'b001, 8'h80, 1'b0, IDLE,   IDLE,   IDLE,   9'h001};
        vecs[7]  = '{95,  5'd31, 3'b100, 8'h00, 1'b0, IDLE,   IDLE,   IDLE,   IDLE};
        vecs[8]  = '{96,  5'd0,  3'b001, 8'h01, 1'b1, 9'h001, IDLE,   IDLE,   IDLE};
        vecs[9]  = '{97,  5'd0,  3'b010, 8'h00, 1'b0, 9'h001, IDLE,   IDLE,   IDLE};
        vecs[10] = '{192, 5'd0,  3'b001, 8'h01, 1'b1, 9'h001, IDLE,   IDLE,   IDLE};
        vecs[11] = '{193, 5'd0,  3'b010, 8'h00, 1'b0, 9'h001, IDLE,   IDLE,   IDLE};

        // Table: free run from reset
        do_reset();
        edges = 0;
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].edge_n - edges);
            edges = vecs[i].edge_n;
            check($sformatf("major@%0d", edges),  major_step,        vecs[i].major);
            check($sformatf("minor@%0d", edges),  minor_step,        vecs[i].minor);
            check($sformatf("pulse@%0d", edges),  voice_s1_pulse,    vecs[i].pulse);
            check($sformatf("strobe@%0d", edges), sample_strobe,     vecs[i].strobe);
            check($sformatf("v0@%0d", edges),     voice_state[8:0],   vecs[i].v0);
            check($sformatf("v1@%0d", edges),     voice_state[17:9],  vecs[i].v1);
            check($sformatf("v2@%0d", edges),     voice_state[26:18], vecs[i].v2);
            check($sformatf("v7@%0d", edges),     voice_state[71:63], vecs[i].v7);
        end

        // Strobe fires after edges 96 and 192 only
        do_reset();
        for (int e = 1; e <= 200; e++) begin
            step(1);
            check($sformatf("strobe_scan@%0d", e), sample_strobe, (e == 96) || (e == 192));
        end
`ifdef DSP_SCHED_SAMPLE_COUNT_EN
        check("sample_count@200", sample_count, 16'd2);
`endif

        // run low mid-step at major 5: outputs hold, then strobe slips by 10
        do_reset();
        step(16);
        check("hold_major_pre", major_step, 5'd5);
        check("hold_minor_pre", minor_step, 3'b010);
        run = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            check("hold_major", major_step, 5'd5);
            check("hold_minor", minor_step, 3'b010);
            check("hold_pulse", voice_s1_pulse, 8'h00);
            check("hold_strobe", sample_strobe, 1'b0);
            check("hold_v0", voice_state[8:0], 9'h020);
            check("hold_v1", voice_state[17:9], 9'h004);
        end
        run = 1'b1;
        step(79);
        check("slip_strobe_early", sample_strobe, 1'b0);
        check("slip_major_31", major_step, 5'd31);
        check("slip_minor_msb", minor_step, 3'b100);
        step(1);
        check("slip_strobe", sample_strobe, 1'b1);
        check("slip_major_0", major_step, 5'd0);

        // Pulse deasserts after one cycle and does not re-fire while held
        do_reset();
        step(9);
        check("phold_pulse_fire", voice_s1_pulse, 8'h02);
        run = 1'b0;
        step(1);
        check("phold_pulse_drop", voice_s1_pulse, 8'h00);
        step(3);
        check("phold_pulse_quiet", voice_s1_pulse, 8'h00);
        check("phold_major", major_step, 5'd3);
        run = 1'b1;

        // Restart at major 20 with run low
        do_reset();
        step(60);
        check("rst20_major_pre", major_step, 5'd20);
        run     = 1'b0;
        restart = 1'b1;
        step(1);
        check("restart_major", major_step, 5'd0);
        check("restart_minor", minor_step, 3'b001);
        check("restart_pulse", voice_s1_pulse, 8'h00);
        check("restart_strobe", sample_strobe, 1'b0);
        check("restart_v0", voice_state[8:0], 9'h001);
        check("restart_v7", voice_state[71:63], IDLE);
`ifdef DSP_SCHED_SAMPLE_COUNT_EN
        check("restart_count", sample_count, 16'd0);
`endif
        restart = 1'b0;
        run     = 1'b1;
        step(3);
        check("restart_resume_major", major_step, 5'd1);

        // Restart on the wrapping edge with run high: no strobe, no pulse
        do_reset();
        step(95);
        restart = 1'b1;
        step(1);
        check("wrap_restart_major", major_step, 5'd0);
        check("wrap_restart_minor", minor_step, 3'b001);
        check("wrap_restart_strobe", sample_strobe, 1'b0);
        check("wrap_restart_pulse", voice_s1_pulse, 8'h00);
        restart = 1'b0;
        step(95);
        check("wrap_restart_95", sample_strobe, 1'b0);
        step(1);
        check("wrap_restart_96", sample_strobe, 1'b1);

        // Asynchronous reset mid-period, checked between clock edges
        do_reset();
        step(50);
        #2;
        reset = 1'b0;
        #1;
        check("areset_major", major_step, 5'd0);
        check("areset_minor", minor_step, 3'b001);
        check("areset_pulse", voice_s1_pulse, 8'h00);
        check("areset_strobe", sample_strobe, 1'b0);
        check("areset_voices", voice_state, {{7{IDLE}}, 9'h001});
        do_reset();
        step(1);
        check("areset_release_minor", minor_step, 3'b010);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
